// File: rtl/decoder_pkg.sv
// decoder_pkg: types and constants shared by the sequential 2-to-4 decoder.
//   state_e     : FSM state (IDLE, HOLD)
//   code_t      : 2-bit code {A,B}
//   QUEUE_DEPTH : entry count of the optional input FIFO
//   decode_1hot : code to one-hot {Y3,Y2,Y1,Y0}
package decoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [1:0] code_t;

    localparam int unsigned QUEUE_DEPTH = 4;

    function automatic logic [3:0] decode_1hot(input code_t code);
        return 4'(4'b0001 << code);
    endfunction

endpackage

// File: rtl/code_fifo.sv
// code_fifo: small synchronous FIFO of 2-bit codes.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write data_i (ignored when full)
//   data_i     : code to store
//   pop_i      : discard head entry (ignored when empty)
//   data_o     : head entry (valid while !empty_o)
//   full_o     : no free entry
//   empty_o    : no stored entry
module code_fifo
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  code_t data_i,
    input  logic  pop_i,
    output code_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    code_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_c = push_i & ~full_o;
    assign do_pop_c  = pop_i & ~empty_o;

    // Pointer/occupancy next state; simultaneous push+pop keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/decoder_2to4_seq.sv
// decoder_2to4_seq: accepts a 2-bit code {A,B} on a valid/ready handshake and
// holds the matching one-hot output high for HOLD_CYCLES cycles.
//   clk, rst_n   : clock, synchronous active-low reset
//   A, B         : code MSB / LSB
//   in_valid     : A/B carry a code
//   in_ready     : code is accepted this cycle (0 during reset)
//   Y0..Y3       : registered one-hot decoded outputs
//   busy         : a hold is in progress
// Build option: define DECODER_QUEUE_EN to place a QUEUE_DEPTH-entry FIFO
// between the handshake and the FSM; otherwise the FSM is fed directly.
module decoder_2to4_seq
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic in_valid,
    output logic in_ready,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       y_q, y_d;
    logic             busy_q, busy_d;

    logic             final_c;
    logic             slot_c;
    logic             take_c;
    code_t            take_code_c;

    // A new code may start in IDLE or in the last cycle of a hold.
    assign final_c = (state_q == HOLD) && (cnt_q == CNT_LAST);
    assign slot_c  = (state_q == IDLE) || final_c;

`ifdef DECODER_QUEUE_EN
    code_t fifo_head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push_c;

    assign in_ready    = rst_n & ~fifo_full;
    assign push_c      = in_valid & in_ready;
    assign take_c      = rst_n & slot_c & ~fifo_empty;
    assign take_code_c = fifo_head;

    code_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  ({A, B}),
        .pop_i   (take_c),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign in_ready    = rst_n & slot_c;
    assign take_c      = in_valid & in_ready;
    assign take_code_c = {A, B};
`endif

    // Next-state: load on a new code, count while holding, drop to IDLE at end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (take_c) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    y_d     = decode_1hot(take_code_c);
                    busy_d  = 1'b1;
                end
            end
            HOLD: begin
                if (final_c) begin
                    if (take_c) begin
                        cnt_d = '0;
                        y_d   = decode_1hot(take_code_c);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        y_d     = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                y_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    assign {Y3, Y2, Y1, Y0} = y_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Directed table-driven bench: one instance with HOLD_CYCLES=4, one with 1.
module tb_decoder_2to4_seq;

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [1:0] code;
        logic [3:0] y;      // {Y3,Y2,Y1,Y0} expected this cycle
        logic       busy;
        logic       rdy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, v4, a4, b4, rdy4, busy4;
    logic y40, y41, y42, y43;
    logic rst1, v1, a1, b1, rdy1, busy1;
    logic y10, y11, y12, y13;

    decoder_2to4_seq #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst4), .A(a4), .B(b4), .in_valid(v4), .in_ready(rdy4),
        .Y0(y40), .Y1(y41), .Y2(y42), .Y3(y43), .busy(busy4)
    );

    decoder_2to4_seq #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1), .A(a1), .B(b1), .in_valid(v1), .in_ready(rdy1),
        .Y0(y10), .Y1(y11), .Y2(y12), .Y3(y13), .busy(busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t tab4 [25];
    vec_t tab1 [7];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c,
                                input logic [3:0] y, input logic b, input logic rd);
        vec_t t;
        t.rst_n = r; t.valid = v; t.code = c; t.y = y; t.busy = b; t.rdy = rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {Y3..Y0,busy,rdy}=%b required %b", name, got, exp);
        end
    endtask

    function automatic logic [5:0] obs4();
        return {y43, y42, y41, y40, busy4, rdy4};
    endfunction

    function automatic logic [5:0] obs1();
        return {y13, y12, y11, y10, busy1, rdy1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // H=4: single code 10, then 00,01,10,11 back-to-back with valid held.
        tab4[0]  = mk(0, 0, 2'b00, 4'b0000, 0, 0);
        tab4[1]  = mk(1, 0, 2'b00, 4'b0000, 0, 1);
        tab4[2]  = mk(1, 1, 2'b10, 4'b0000, 0, 1);
        tab4[3]  = mk(1, 0, 2'b10, 4'b0100, 1, 0);
        tab4[4]  = mk(1, 0, 2'b00, 4'b0100, 1, 0);
        tab4[5]  = mk(1, 0, 2'b00, 4'b0100, 1, 0);
        tab4[6]  = mk(1, 0, 2'b00, 4'b0100, 1, 1);
        tab4[7]  = mk(1, 1, 2'b00, 4'b0000, 0, 1);
        tab4[8]  = mk(1, 1, 2'b01, 4'b0001, 1, 0);
        tab4[9]  = mk(1, 1, 2'b01, 4'b0001, 1, 0);
        tab4[10] = mk(1, 1, 2'b01, 4'b0001, 1, 0);
        tab4[11] = mk(1, 1, 2'b01, 4'b0001, 1, 1);
        tab4[12] = mk(1, 1, 2'b10, 4'b0010, 1, 0);
        tab4[13] = mk(1, 1, 2'b10, 4'b0010, 1, 0);
        tab4[14] = mk(1, 1, 2'b10, 4'b0010, 1, 0);
        tab4[15] = mk(1, 1, 2'b10, 4'b0010, 1, 1);
        tab4[16] = mk(1, 1, 2'b11, 4'b0100, 1, 0);
        tab4[17] = mk(1, 1, 2'b11, 4'b0100, 1, 0);
        tab4[18] = mk(1, 1, 2'b11, 4'b0100, 1, 0);
        tab4[19] = mk(1, 1, 2'b11, 4'b0100, 1, 1);
        tab4[20] = mk(1, 0, 2'b00, 4'b1000, 1, 0);
        tab4[21] = mk(1, 0, 2'b00, 4'b1000, 1, 0);
        tab4[22] = mk(1, 0, 2'b00, 4'b1000, 1, 0);
        tab4[23] = mk(1, 0, 2'b00, 4'b1000, 1, 1);
        tab4[24] = mk(1, 0, 2'b00, 4'b0000, 0, 1);

        // H=1: stream 11,11,00 -> Y3 two cycles, Y0 one cycle, idle.
        tab1[0] = mk(0, 0, 2'b00, 4'b0000, 0, 0);
        tab1[1] = mk(1, 0, 2'b00, 4'b0000, 0, 1);
        tab1[2] = mk(1, 1, 2'b11, 4'b0000, 0, 1);
        tab1[3] = mk(1, 1, 2'b11, 4'b1000, 1, 1);
        tab1[4] = mk(1, 1, 2'b00, 4'b1000, 1, 1);
        tab1[5] = mk(1, 0, 2'b00, 4'b0001, 1, 1);
        tab1[6] = mk(1, 0, 2'b00, 4'b0000, 0, 1);

        rst4 = 0; v4 = 0; a4 = 0; b4 = 0;
        rst1 = 0; v1 = 0; a1 = 0; b1 = 0;
        repeat (2) tick();

        for (int i = 0; i < 25; i++) begin
            rst4 = tab4[i].rst_n; v4 = tab4[i].valid;
            {a4, b4} = tab4[i].code;
            #1;
            check($sformatf("h4_row%0d", i), obs4(),
                  {tab4[i].y, tab4[i].busy, tab4[i].rdy});
            tick();
        end

        for (int i = 0; i < 7; i++) begin
            rst1 = tab1[i].rst_n; v1 = tab1[i].valid;
            {a1, b1} = tab1[i].code;
            #1;
            check($sformatf("h1_row%0d", i), obs1(),
                  {tab1[i].y, tab1[i].busy, tab1[i].rdy});
            tick();
        end

        // Reset during cycle 2 of a hold on Y1.
        rst4 = 1; v4 = 1; {a4, b4} = 2'b01;
        tick();
        v4 = 0;
        check("rst_hold_c1", obs4(), {4'b0010, 1'b1, 1'b0});
        tick();
        check("rst_hold_c2", obs4(), {4'b0010, 1'b1, 1'b0});
        rst4 = 0;
        #1;
        check("rst_rdy_low", obs4(), {4'b0010, 1'b1, 1'b0});
        tick();
        check("rst_abort", obs4(), {4'b0000, 1'b0, 1'b0});
        rst4 = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("post_rst%0d", i), obs4(), {4'b0000, 1'b0, 1'b1});
            tick();
        end

        // A/B toggling with in_valid low must be ignored.
        for (int i = 0; i < 20; i++) begin
            v4 = 0;
            a4 = 1'($urandom_range(0, 1));
            b4 = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("idle_noise%0d", i), obs4(), {4'b0000, 1'b0, 1'b1});
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
